// File: rtl/pll_pkg.sv
// Shared types and width helpers for the PFD-driven loop filter.
// The FSM state enum and the widths derived from the loop parameters live here.
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } pll_state_t;

    localparam int DEF_CW  = 12;
    localparam int DEF_WIN = 16;
    localparam int DEF_MID = 1 << (DEF_CW - 1);

    // Bits for a counter spanning 0..n-1 (never less than one bit).
    function automatic int win_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed error accumulator wide enough for [-win, +win].
    function automatic int err_width(input int win);
        return $clog2(win) + 2;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pfd_loop_filter.sv
// PI loop filter over windowed PFD up/down counts, producing a clamped
// oscillator control word plus acquire/track lock detection.
module pfd_loop_filter
    import pll_pkg::*;
#(
    parameter int CW       = 12,
    parameter int WIN      = 16,
    parameter int KP_SHIFT = 2,
    parameter int KI_SHIFT = 4,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          up,
    input  logic          dn,
    output logic [CW-1:0] ctrl,
    output logic          ctrl_vld,
    output logic          lock,
    output logic          sat_hi,
    output logic          sat_lo
);

    localparam int EW  = err_width(WIN);
    localparam int WW  = win_width(WIN);
    localparam int IW  = CW + KI_SHIFT;
    localparam int SW  = IW + EW + KP_SHIFT + 2;
    localparam int LCW = win_width(LOCK_CNT) + 1;

    localparam logic [WW-1:0]         WIN_LAST  = WW'(WIN - 1);
    localparam logic [LCW-1:0]        LOCK_LAST = LCW'(LOCK_CNT - 1);
    localparam logic signed [EW-1:0]  TOL_E     = EW'(LOCK_TOL);
    localparam logic signed [IW:0]    INTEG_HI  = {2'b00, {(IW-1){1'b1}}};
    localparam logic signed [IW:0]    INTEG_LO  = {2'b11, {(IW-1){1'b0}}};
    localparam logic signed [SW-1:0]  MID_S     = {{(SW-CW){1'b0}}, 1'b1, {(CW-1){1'b0}}};
    localparam logic signed [SW-1:0]  CTRL_MAX  = {{(SW-CW){1'b0}}, {CW{1'b1}}};
    localparam logic [CW-1:0]         MID_C     = {1'b1, {(CW-1){1'b0}}};

    logic w_up_s;
    logic w_dn_s;

    sync2 u_sync_up (.clk(clk), .rst(rst), .i_d(up), .o_q(w_up_s));
    sync2 u_sync_dn (.clk(clk), .rst(rst), .i_d(dn), .o_q(w_dn_s));

    pll_state_t             r_state;
    logic signed [EW-1:0]   r_err;
    logic [WW-1:0]          r_win;
    logic [LCW-1:0]         r_tol_cnt;
    logic signed [IW-1:0]   r_integ;
    logic [CW-1:0]          r_ctrl;
    logic                   r_vld;
    logic                   r_lock;
    logic                   r_sat_hi;
    logic                   r_sat_lo;

    logic signed [EW-1:0]   w_err_step;
    logic signed [EW-1:0]   w_err_sum;
    logic signed [EW-1:0]   w_err_abs;
    logic                   w_in_tol;
    logic                   w_win_last;
    logic signed [IW:0]     w_integ_sum;
    logic signed [IW-1:0]   w_integ_next;
    logic signed [IW-1:0]   w_integ_shr;
    logic signed [SW-1:0]   w_i_term;
    logic signed [SW-1:0]   w_p_term;
    logic signed [SW-1:0]   w_sum;
    logic                   w_sat_hi;
    logic                   w_sat_lo;
    logic [CW-1:0]          w_ctrl_next;

    always_comb begin
        w_err_step = '0;
        if (w_up_s && !w_dn_s) begin
            w_err_step = {{(EW-1){1'b0}}, 1'b1};
        end else if (w_dn_s && !w_up_s) begin
            w_err_step = {EW{1'b1}};
        end
    end

    // The closing cycle's own contribution is folded in before the filter update.
    assign w_err_sum  = r_err + w_err_step;
    assign w_err_abs  = w_err_sum[EW-1] ? -w_err_sum : w_err_sum;
    assign w_in_tol   = (w_err_abs <= TOL_E);
    assign w_win_last = (r_win == WIN_LAST);

    assign w_integ_sum = {r_integ[IW-1], r_integ}
                       + {{(IW+1-EW){w_err_sum[EW-1]}}, w_err_sum};

    always_comb begin
        w_integ_next = w_integ_sum[IW-1:0];
        if (w_integ_sum > INTEG_HI) begin
            w_integ_next = INTEG_HI[IW-1:0];
        end else if (w_integ_sum < INTEG_LO) begin
            w_integ_next = INTEG_LO[IW-1:0];
        end
    end

    // Full-width sum; the clamp to the unsigned control range happens afterwards.
    assign w_integ_shr = w_integ_next >>> KI_SHIFT;
    assign w_i_term    = {{(SW-IW){w_integ_shr[IW-1]}}, w_integ_shr};
    assign w_p_term    = {{(SW-EW){w_err_sum[EW-1]}}, w_err_sum} <<< KP_SHIFT;
    assign w_sum       = MID_S + w_i_term + w_p_term;
    assign w_sat_hi    = (w_sum > CTRL_MAX);
    assign w_sat_lo    = w_sum[SW-1];

    always_comb begin
        w_ctrl_next = w_sum[CW-1:0];
        if (w_sat_hi) begin
            w_ctrl_next = {CW{1'b1}};
        end else if (w_sat_lo) begin
            w_ctrl_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_err     <= '0;
            r_win     <= '0;
            r_tol_cnt <= '0;
            r_integ   <= '0;
            r_ctrl    <= MID_C;
            r_vld     <= 1'b0;
            r_lock    <= 1'b0;
            r_sat_hi  <= 1'b0;
            r_sat_lo  <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (!en) begin
                // Dropping enable, even on a closing cycle, discards the partial window.
                r_state   <= IDLE;
                r_err     <= '0;
                r_win     <= '0;
                r_tol_cnt <= '0;
                r_lock    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ACQUIRE;
                    end
                    ACQUIRE, TRACK: begin
                        if (w_win_last) begin
                            r_err    <= '0;
                            r_win    <= '0;
                            r_integ  <= w_integ_next;
                            r_ctrl   <= w_ctrl_next;
                            r_sat_hi <= w_sat_hi;
                            r_sat_lo <= w_sat_lo;
                            r_vld    <= 1'b1;
                            if (!w_in_tol) begin
                                r_tol_cnt <= '0;
                                r_state   <= ACQUIRE;
                                r_lock    <= 1'b0;
                            end else if (r_state == ACQUIRE) begin
                                if (r_tol_cnt == LOCK_LAST) begin
                                    r_tol_cnt <= '0;
                                    r_state   <= TRACK;
                                    r_lock    <= 1'b1;
                                end else begin
                                    r_tol_cnt <= r_tol_cnt + 1'b1;
                                end
                            end
                        end else begin
                            r_err <= w_err_sum;
                            r_win <= r_win + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctrl     = r_ctrl;
    assign ctrl_vld = r_vld;
    assign lock     = r_lock;
    assign sat_hi   = r_sat_hi;
    assign sat_lo   = r_sat_lo;

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Directed bench for pfd_loop_filter at default parameters (MID = 2048).
module tb_pfd_loop_filter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up;
    logic        dn;
    logic [11:0] ctrl;
    logic        ctrl_vld;
    logic        lock;
    logic        sat_hi;
    logic        sat_lo;

    int n_checks = 0;
    int n_fail   = 0;

    pfd_loop_filter dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .dn       (dn),
        .ctrl     (ctrl),
        .ctrl_vld (ctrl_vld),
        .lock     (lock),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Returns the number of negedges until ctrl_vld is seen, or -1 on timeout.
    task automatic wait_vld(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (ctrl_vld) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (ctrl !== 12'd2048) begin n_fail++; $display("FAIL reset_ctrl: got %0d expected 2048", ctrl); end
        n_checks++; if (ctrl_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", ctrl_vld); end
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b expected 0", lock); end
        n_checks++; if (sat_hi !== 1'b0) begin n_fail++; $display("FAIL reset_sat_hi: got %b expected 0", sat_hi); end
        n_checks++; if (sat_lo !== 1'b0) begin n_fail++; $display("FAIL reset_sat_lo: got %b expected 0", sat_lo); end
        $display("test_reset: ctrl=%0d lock=%b", ctrl, lock);
    endtask

    task automatic test_up();
        int cyc;
        up = 1'b1; dn = 1'b0;
        do_reset();
        en = 1'b1;
        wait_vld(40, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL up_latency: got %0d expected 17", cyc); end
        n_checks++; if (ctrl !== 12'd2113) begin n_fail++; $display("FAIL up_ctrl: got %0d expected 2113", ctrl); end
        n_checks++; if (sat_hi !== 1'b0 || sat_lo !== 1'b0) begin n_fail++; $display("FAIL up_sat: got %b%b expected 00", sat_hi, sat_lo); end
        @(negedge clk);
        n_checks++; if (ctrl_vld !== 1'b0) begin n_fail++; $display("FAIL up_vld_pulse: got %b expected 0", ctrl_vld); end
        wait_vld(40, cyc);
        n_checks++; if (cyc !== 15) begin n_fail++; $display("FAIL up_second_latency: got %0d expected 15", cyc); end
        n_checks++; if (ctrl !== 12'd2114) begin n_fail++; $display("FAIL up_second_ctrl: got %0d expected 2114", ctrl); end
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL up_lock: got %b expected 0", lock); end
        $display("test_up: ctrl=%0d", ctrl);
    endtask

    task automatic test_dn_and_both();
        int cyc;
        up = 1'b0; dn = 1'b1;
        do_reset();
        en = 1'b1;
        wait_vld(40, cyc);
        n_checks++; if (ctrl !== 12'd1983) begin n_fail++; $display("FAIL dn_ctrl: got %0d expected 1983", ctrl); end
        n_checks++; if (sat_lo !== 1'b0) begin n_fail++; $display("FAIL dn_sat_lo: got %b expected 0", sat_lo); end
        $display("test_dn: ctrl=%0d", ctrl);
        up = 1'b1; dn = 1'b1;
        do_reset();
        en = 1'b1;
        wait_vld(40, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL both_latency: got %0d expected 17", cyc); end
        n_checks++; if (ctrl !== 12'd2048) begin n_fail++; $display("FAIL both_ctrl: got %0d expected 2048", ctrl); end
        $display("test_both: ctrl=%0d", ctrl);
    endtask

    task automatic test_lock();
        int cyc;
        up = 1'b0; dn = 1'b0;
        do_reset();
        en = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            wait_vld(40, cyc);
            n_checks++; if (lock !== (w == 4)) begin n_fail++; $display("FAIL lock_window%0d: got %b expected %b", w, lock, (w == 4)); end
            n_checks++; if (ctrl !== 12'd2048) begin n_fail++; $display("FAIL lock_ctrl%0d: got %0d expected 2048", w, ctrl); end
        end
        repeat (2) @(negedge clk);
        up = 1'b1;
        repeat (5) @(negedge clk);
        up = 1'b0;
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL lock_midwindow: got %b expected 1", lock); end
        wait_vld(40, cyc);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL unlock_latency: got %0d expected 9", cyc); end
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL unlock: got %b expected 0", lock); end
        n_checks++; if (ctrl !== 12'd2068) begin n_fail++; $display("FAIL unlock_ctrl: got %0d expected 2068", ctrl); end
        $display("test_lock: ctrl=%0d lock=%b", ctrl, lock);
    endtask

    task automatic test_en_drop();
        int cyc;
        up = 1'b1; dn = 1'b0;
        do_reset();
        en = 1'b1;
        wait_vld(40, cyc);
        repeat (5) @(negedge clk);
        en = 1'b0;
        wait_vld(30, cyc);
        n_checks++; if (cyc !== -1) begin n_fail++; $display("FAIL en_drop_vld: got %0d expected -1", cyc); end
        n_checks++; if (ctrl !== 12'd2113) begin n_fail++; $display("FAIL en_drop_ctrl: got %0d expected 2113", ctrl); end
        en = 1'b1;
        wait_vld(40, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL en_raise_latency: got %0d expected 17", cyc); end
        n_checks++; if (ctrl !== 12'd2114) begin n_fail++; $display("FAIL en_raise_ctrl: got %0d expected 2114", ctrl); end
        $display("test_en_drop: ctrl=%0d", ctrl);
    endtask

    task automatic test_en_close();
        int cyc;
        up = 1'b1; dn = 1'b0;
        do_reset();
        en = 1'b1;
        wait_vld(40, cyc);
        repeat (15) @(negedge clk);
        en = 1'b0;
        wait_vld(20, cyc);
        n_checks++; if (cyc !== -1) begin n_fail++; $display("FAIL en_close_vld: got %0d expected -1", cyc); end
        n_checks++; if (ctrl !== 12'd2113) begin n_fail++; $display("FAIL en_close_ctrl: got %0d expected 2113", ctrl); end
        en = 1'b1;
        wait_vld(40, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL en_close_relatency: got %0d expected 17", cyc); end
        n_checks++; if (ctrl !== 12'd2114) begin n_fail++; $display("FAIL en_close_rectrl: got %0d expected 2114", ctrl); end
        $display("test_en_close: ctrl=%0d", ctrl);
    endtask

    task automatic test_async_reset();
        int cyc;
        up = 1'b1; dn = 1'b0;
        do_reset();
        en = 1'b1;
        wait_vld(40, cyc);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (ctrl !== 12'd2048) begin n_fail++; $display("FAIL arst_ctrl: got %0d expected 2048", ctrl); end
        n_checks++; if (ctrl_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld: got %b expected 0", ctrl_vld); end
        @(negedge clk);
        rst = 1'b0;
        // en stays high: synchronizers restart from 0, so the first window sees 15 up cycles.
        wait_vld(40, cyc);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL arst_resume_latency: got %0d expected 17", cyc); end
        n_checks++; if (ctrl !== 12'd2108) begin n_fail++; $display("FAIL arst_resume_ctrl: got %0d expected 2108", ctrl); end
        up = 1'b0;
        do_reset();
        en = 1'b1;
        for (int w = 1; w <= 4; w++) wait_vld(40, cyc);
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL arst_pre_lock: got %b expected 1", lock); end
        repeat (6) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL arst_lock: got %b expected 0", lock); end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        $display("test_async_reset: ctrl=%0d lock=%b", ctrl, lock);
    endtask

    task automatic test_saturation();
        int cyc;
        int expv;
        int integ_m;
        int err_m;
        logic [11:0] prev;
        up = 1'b1; dn = 1'b0;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 1984; k++) begin
            wait_vld(40, cyc);
            expv = 2112 + k;
            n_checks++;
            if (ctrl !== ((expv > 4095) ? 12'd4095 : expv[11:0]) || sat_hi !== (expv > 4095)) begin
                n_fail++;
                $display("FAIL sat_ramp k=%0d: got ctrl=%0d sat_hi=%b expected ctrl=%0d sat_hi=%b",
                         k, ctrl, sat_hi, (expv > 4095) ? 4095 : expv, (expv > 4095));
                break;
            end
        end
        $display("test_saturation ramp: ctrl=%0d sat_hi=%b", ctrl, sat_hi);
        up = 1'b0; dn = 1'b1;
        integ_m = 16 * 1984;
        prev = ctrl;
        for (int j = 1; j <= 5; j++) begin
            wait_vld(40, cyc);
            err_m = (j == 1) ? -12 : -16;
            integ_m = integ_m + err_m;
            expv = 2048 + (integ_m >>> 4) + err_m * 4;
            n_checks++; if (ctrl !== expv[11:0] || cyc == -1) begin n_fail++; $display("FAIL sat_fall_ctrl j=%0d: got %0d expected %0d", j, ctrl, expv); end
            n_checks++; if (sat_hi !== 1'b0 || sat_lo !== 1'b0) begin n_fail++; $display("FAIL sat_fall_flags j=%0d: got %b%b expected 00", j, sat_hi, sat_lo); end
            n_checks++; if (!(ctrl < prev)) begin n_fail++; $display("FAIL sat_fall_monotonic j=%0d: got %0d previous %0d", j, ctrl, prev); end
            prev = ctrl;
        end
        $display("test_saturation fall: ctrl=%0d", ctrl);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        up  = 1'b0;
        dn  = 1'b0;
        test_reset();
        test_up();
        test_dn_and_both();
        test_lock();
        test_en_drop();
        test_en_close();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pfd_loop_filter.md
PFD_LOOP_FILTER -- requirements
Module: pfd_loop_filter

Interface
REQ-001 Parameter CW, default 12: control word width in bits.
REQ-002 Parameter WIN, default 16: update window length in clk cycles (power of two, 4..256).
REQ-003 Parameter KP_SHIFT, default 2: proportional gain as a left shift of the window error.
REQ-004 Parameter KI_SHIFT, default 4: integral gain as a right shift of the integrator.
REQ-005 Parameter LOCK_TOL, default 2: maximum |window error| that counts as in-lock.
REQ-006 Parameter LOCK_CNT, default 4: consecutive in-tolerance windows required to declare lock.
REQ-007 clk  in  1  single system clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 en  in  1  synchronous enable; low holds the loop.
REQ-010 up  in  1  PFD "up" output (feedback late); asynchronous to clk.
REQ-011 dn  in  1  PFD "down" output (feedback early); asynchronous to clk.
REQ-012 ctrl  out  CW  unsigned oscillator control word.
REQ-013 ctrl_vld  out  1  one-cycle pulse when ctrl is updated.
REQ-014 lock  out  1  loop-locked indication.
REQ-015 sat_hi / sat_lo  out  1 each  ctrl is clamped at max / min.

Function
REQ-016 up and dn each pass through a two-flop synchronizer; all downstream logic uses only the synchronized versions (2-cycle input latency).
REQ-017 Per cycle while running: err += 1 if up_s & ~dn_s; err -= 1 if dn_s & ~up_s; unchanged if both or neither.
REQ-018 err is signed, covering [-WIN, +WIN] without overflow.
REQ-019 A window counter counts 0..WIN-1; at count WIN-1 the window closes, including that cycle's contribution.
REQ-020 On window close: integ_next = clamp(integ + err) with integ limited to [-(MID<<KI_SHIFT), (MID<<KI_SHIFT)-1], MID = 2^(CW-1).
REQ-021 On the cycle after window close, ctrl = clamp(MID + (integ_next >>> KI_SHIFT) + (err <<< KP_SHIFT), 0, 2^CW-1), computed at full width before the clamp; ctrl_vld pulses in the same cycle; err and window counter restart.
REQ-022 sat_hi = 1 iff the unclamped sum exceeded 2^CW-1; sat_lo = 1 iff it was below 0; both update only with ctrl.
REQ-023 FSM states IDLE, ACQUIRE, TRACK.
REQ-024 IDLE -> ACQUIRE when en=1; ACQUIRE/TRACK -> IDLE when en=0.
REQ-025 ACQUIRE -> TRACK when LOCK_CNT consecutive closed windows had |err| <= LOCK_TOL; TRACK -> ACQUIRE on any closed window with |err| > LOCK_TOL.
REQ-026 lock = 1 only in TRACK.
REQ-027 In IDLE: ctrl, integ, sat flags held; err, window counter, and in-tolerance counter cleared; partial window discarded; no ctrl_vld.
REQ-028 en falling on the window-close cycle: that window is discarded, with no update.

Reset
REQ-029 rst asynchronously forces ctrl = MID, integ = 0, err = 0, window and in-tolerance counters = 0, synchronizer flops = 0, FSM = IDLE, and ctrl_vld, lock, sat_hi, sat_lo = 0.
REQ-030 Reset mid-window or in TRACK behaves identically; operation resumes from the reset values on the first clk edge after rst deasserts with en=1.

Structure
REQ-031 Shared package pll_pkg holds the FSM state enum (IDLE, ACQUIRE, TRACK) and the width and MID helper constants.
REQ-032 Sub-module sync2 is the two-flop synchronizer, instantiated once each for up and dn; the filter, FSM, and lock logic stay in pfd_loop_filter.

Verification (default parameters, MID = 2048)
REQ-033 up=1, dn=0 held, en=1, one window -> err=+16, integ=16, ctrl=2048+1+64=2113, ctrl_vld pulses once.
REQ-034 dn=1, up=0 held, one window -> integ=-16, ctrl=2048-1-64=1983; up=dn=1 held -> ctrl stays 2048.
REQ-035 up=1 held for many windows -> ctrl reaches 4095, sat_hi=1, no wrap; then dn=1 held -> sat_hi clears and ctrl decreases monotonically.
REQ-036 up=dn=0 for 4 windows -> lock=1 after the 4th ctrl_vld; one window with 5 up cycles -> lock=0 at the next ctrl_vld.
REQ-037 en dropped mid-window -> ctrl frozen, no ctrl_vld; en re-raised -> full new window before the next update.
REQ-038 rst pulsed mid-window in TRACK with ctrl=2113 -> ctrl=2048 and lock=0 immediately, without waiting for a clk edge.
